// File: rtl/sram_mem_controller.sv
// sram_mem_controller: splits 32-bit MEM-stage loads/stores into two half-word SRAM phases.
// Define MEM_READ_BUF_EN to add a one-entry read buffer.
module sram_mem_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam int WW = SRAM_AW - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [WW-1:0]      word_q, word_d, word_in;
    logic [15:0]        whi_q, whi_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dq_q, dq_d;
    logic               last, hit;

    assign word_in    = WW'((address - 32'(BASE_ADDR)) >> 2);
    assign last       = cnt_q == 4'(WAIT_CYCLES - 1);
    assign ready      = (state_q == IDLE && (!(wr_en || rd_en) || hit)) || state_q == DONE;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_q;
    assign sram_dq_oe = wr_q && (state_q == LOW || state_q == HIGH);
    assign sram_we_n  = !(sram_dq_oe && (!last || WAIT_CYCLES == 1));

`ifdef MEM_READ_BUF_EN
    logic          buf_v_q, buf_v_d;
    logic [WW-1:0] buf_tag_q, buf_tag_d;
    logic [31:0]   buf_data_q, buf_data_d;

    assign hit       = buf_v_q && state_q == IDLE && rd_en && !wr_en && buf_tag_q == word_in;
    assign read_data = hit ? buf_data_q : rdata_q;

    // Buffer fills from a finishing read and follows stores to the tagged word
    always_comb begin
        buf_v_d    = buf_v_q;
        buf_tag_d  = buf_tag_q;
        buf_data_d = buf_data_q;
        if (state_q == HIGH && last && !wr_q) begin
            buf_v_d    = 1'b1;
            buf_tag_d  = word_q;
            buf_data_d = {sram_dq_i, rdata_q[15:0]};
        end
        if (state_q == IDLE && wr_en && buf_tag_q == word_in)
            buf_data_d = write_data;
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v_q    <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
        end else begin
            buf_v_q    <= buf_v_d;
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
        end
    end
`else
    assign hit       = 1'b0;
    assign read_data = rdata_q;
`endif

    // Next state: latch the request in IDLE, then walk the low and high phases
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        word_d  = word_q;
        whi_d   = whi_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        case (state_q)
            IDLE: if ((wr_en || rd_en) && !hit) begin
                state_d = LOW;
                cnt_d   = '0;
                wr_d    = wr_en;
                word_d  = word_in;
                whi_d   = write_data[31:16];
                addr_d  = {word_in, 1'b0};
                if (wr_en) dq_d = write_data[15:0];
            end
            LOW: begin
                cnt_d = cnt_q + 4'd1;
                if (last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    addr_d  = {word_q, 1'b1};
                    if (wr_q) dq_d = whi_q;
                    else rdata_d[15:0] = sram_dq_i;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + 4'd1;
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!wr_q) rdata_d[31:16] = sram_dq_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset lands the bus in a safe idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            whi_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            word_q  <= word_d;
            whi_q   <= whi_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: directed vectors for the SRAM controller at WAIT_CYCLES=2 (instance 0) and 1 (instance 1)
module tb_sram_mem_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en, rd_en, ready, we_n, oe;
    logic [31:0] address[2], write_data[2], read_data[2];
    logic [17:0] sram_addr[2];
    logic [15:0] dq_o[2], dq_i[2];
    logic [15:0] mem[2][256];
    int          checks = 0;
    int          failures = 0;

`ifdef MEM_READ_BUF_EN
    localparam int HIT_LAT = 0;
`else
    localparam int HIT_LAT = 5;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(g == 0 ? 2 : 1), .SRAM_AW(18)) u_dut (
            .clk(clk), .rst(rst), .wr_en(wr_en[g]), .rd_en(rd_en[g]),
            .address(address[g]), .write_data(write_data[g]), .read_data(read_data[g]),
            .ready(ready[g]), .sram_addr(sram_addr[g]), .sram_dq_o(dq_o[g]),
            .sram_dq_i(dq_i[g]), .sram_dq_oe(oe[g]), .sram_we_n(we_n[g])
        );
        assign dq_i[g] = mem[g][sram_addr[g][7:0]];
        always @(posedge clk) if (!we_n[g] && oe[g]) mem[g][sram_addr[g][7:0]] <= dq_o[g];
    end

    typedef struct {
        bit          wr, rd;
        logic [31:0] a, wd, rd_exp;
        logic [17:0] lo;
        logic [15:0] lo_d, hi_d;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_access(input int s, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rdv, output logic [17:0] lo_a,
                             output logic [17:0] hi_a, output int we_c, output int oe_c);
        @(negedge clk);
        wr_en[s] = wr; rd_en[s] = rd; address[s] = a; write_data[s] = wd;
        #1;
        lat = 0; we_c = 0; oe_c = 0; lo_a = '0; hi_a = '0;
        we_c += int'(!we_n[s]); oe_c += int'(oe[s]);
        while (!ready[s] && lat < 40) begin
            @(negedge clk); #1;
            lat++;
            if (lat == 1) lo_a = sram_addr[s];
            if (!ready[s]) hi_a = sram_addr[s];
            we_c += int'(!we_n[s]); oe_c += int'(oe[s]);
        end
        rdv = read_data[s];
        wr_en[s] = 1'b0; rd_en[s] = 1'b0;
    endtask

    initial begin
        int          lat, we_c, oe_c;
        logic [31:0] rdv;
        logic [17:0] lo_a, hi_a;
        logic        rdy_exp[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        tv[0] = '{1, 0, 1024, 32'hDEADBEEF, 32'h0,        18'h0,     16'hBEEF, 16'hDEAD};
        tv[1] = '{0, 1, 1036, 32'h0,        32'h12345678, 18'h6,     16'h0,    16'h0};
        tv[2] = '{1, 1, 1028, 32'h0000CAFE, 32'h12345678, 18'h2,     16'hCAFE, 16'h0000};
        tv[3] = '{0, 1, 1024, 32'h0,        32'hDEADBEEF, 18'h0,     16'h0,    16'h0};
        tv[4] = '{1, 0, 1027, 32'h01020304, 32'hDEADBEEF, 18'h0,     16'h0304, 16'h0102};
        tv[5] = '{0, 1, 1020, 32'h0,        32'h5555AAAA, 18'h3FFFE, 16'h0,    16'h0};
        tv[6] = '{0, 1, 1027, 32'h0,        32'h01020304, 18'h0,     16'h0,    16'h0};
        rst = 1'b0;
        wr_en = '0; rd_en = '0;
        for (int i = 0; i < 2; i++) begin
            address[i] = '0; write_data[i] = '0;
            for (int j = 0; j < 256; j++) mem[i][j] <= '0;
        end
        #1;
        mem[0][6] <= 16'h5678; mem[0][7] <= 16'h1234;
        mem[0][254] <= 16'hAAAA; mem[0][255] <= 16'h5555;
        mem[1][0] <= 16'h1111; mem[1][1] <= 16'h2222;
        mem[1][4] <= 16'h3333; mem[1][5] <= 16'h4444;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready[0], 1);
        chk("rst_we_n", we_n[0], 1);
        chk("rst_oe", oe[0], 0);
        chk("rst_addr", sram_addr[0], 0);
        chk("rst_dq_o", dq_o[0], 0);
        chk("rst_rdata", read_data[0], 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_access(0, tv[i].wr, tv[i].rd, tv[i].a, tv[i].wd, lat, rdv, lo_a, hi_a, we_c, oe_c);
            chk($sformatf("v%0d_latency", i), lat, 5);
            chk($sformatf("v%0d_rdata", i), rdv, tv[i].rd_exp);
            chk($sformatf("v%0d_lo_addr", i), lo_a, tv[i].lo);
            chk($sformatf("v%0d_hi_addr", i), hi_a, tv[i].lo | 18'h1);
            chk($sformatf("v%0d_we_cycles", i), we_c, tv[i].wr ? 2 : 0);
            chk($sformatf("v%0d_oe_cycles", i), oe_c, tv[i].wr ? 4 : 0);
            if (tv[i].wr) begin
                chk($sformatf("v%0d_mem_lo", i), mem[0][tv[i].lo[7:0]], tv[i].lo_d);
                chk($sformatf("v%0d_mem_hi", i), mem[0][tv[i].lo[7:0] | 8'h1], tv[i].hi_d);
            end
        end

        @(negedge clk);
        wr_en[0] = 1'b1; address[0] = 1040; write_data[0] = 32'h99998888;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_high_addr", sram_addr[0], 9);
        chk("mid_high_we_n", we_n[0], 0);
        rst = 1'b0; wr_en[0] = 1'b0;
        #1;
        chk("arst_we_n", we_n[0], 1);
        chk("arst_oe", oe[0], 0);
        chk("arst_ready", ready[0], 1);
        chk("arst_addr", sram_addr[0], 0);
        chk("arst_rdata", read_data[0], 0);
        @(negedge clk);
        rst = 1'b1;
        chk("partial_lo", mem[0][8], 16'h8888);
        chk("partial_hi", mem[0][9], 16'h0000);
        do_access(0, 1, 0, 1040, 32'h77776666, lat, rdv, lo_a, hi_a, we_c, oe_c);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_lo", mem[0][8], 16'h6666);
        chk("post_rst_hi", mem[0][9], 16'h7777);

        do_access(0, 0, 1, 1040, 0, lat, rdv, lo_a, hi_a, we_c, oe_c);
        chk("buf_fill_lat", lat, 5);
        chk("buf_fill_rdata", rdv, 32'h77776666);
        do_access(0, 0, 1, 1040, 0, lat, rdv, lo_a, hi_a, we_c, oe_c);
        chk("buf_again_lat", lat, HIT_LAT);
        chk("buf_again_rdata", rdv, 32'h77776666);
        chk("buf_again_addr", sram_addr[0], 9);
        do_access(0, 1, 0, 1040, 32'h00000011, lat, rdv, lo_a, hi_a, we_c, oe_c);
        chk("buf_store_lat", lat, 5);
        do_access(0, 0, 1, 1040, 0, lat, rdv, lo_a, hi_a, we_c, oe_c);
        chk("buf_upd_lat", lat, HIT_LAT);
        chk("buf_upd_rdata", rdv, 32'h00000011);

        @(negedge clk);
        rd_en[1] = 1'b1; address[1] = 1024;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == 4) address[1] = 1032;
                #1;
            end
            chk($sformatf("b2b_ready_c%0d", c), ready[1], rdy_exp[c]);
            if (c == 3) chk("b2b_rdata1", read_data[1], 32'h22221111);
            if (c == 7) chk("b2b_rdata2", read_data[1], 32'h44443333);
        end
        rd_en[1] = 1'b0;
        do_access(1, 1, 0, 1028, 32'hABCD1234, lat, rdv, lo_a, hi_a, we_c, oe_c);
        chk("w1_lat", lat, 3);
        chk("w1_we_cycles", we_c, 2);
        chk("w1_oe_cycles", oe_c, 2);
        chk("w1_mem_lo", mem[1][2], 16'h1234);
        chk("w1_mem_hi", mem[1][3], 16'hABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
